// File: rtl/trig_pkg.sv
// Shared constants and types for the trigger event-completion merger.
package trig_pkg;

    localparam int unsigned NUM_BUFFERS        = 4;
    localparam int unsigned PEND_WIDTH         = 3;
    localparam int unsigned MAX_TIMEOUT_CYCLES = 16_777_215;
    localparam int unsigned TIMEOUT_WIDTH      = $clog2(MAX_TIMEOUT_CYCLES + 1);

    typedef logic [PEND_WIDTH-1:0] pend_t;

    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2
    } pend_op_e;

    // A done that coincides with a retire cancels out.
    function automatic pend_op_e pend_op(input logic done, input logic retire);
        if (done && !retire) return PEND_INC;
        if (retire && !done) return PEND_DEC;
        return PEND_HOLD;
    endfunction

endpackage

// File: rtl/trig_link_pending.sv
// Per-link pending-event counter: counts finished events not yet retired,
// saturating at NUM_BUFFERS and flagging an overflow on a further done.
module trig_link_pending
    import trig_pkg::*;
(
    input  logic  sys_clk_i,
    input  logic  rst_i,
    input  logic  done_i,
    input  logic  retire_i,
    input  logic  mask_i,
    output logic  nonzero_o,
    output logic  overflow_o,
    output pend_t pend_o
);

    pend_t    pend_q;
    pend_t    pend_d;
    pend_op_e op;
    logic     full;

    assign full   = (pend_q == pend_t'(NUM_BUFFERS));
    assign pend_o = pend_q;

    // The incoming done counts as available so a completing strobe retires
    // on the same edge it is sampled.
    assign nonzero_o = !mask_i && ((pend_q != '0) || done_i);

    always_comb begin
        op         = pend_op(done_i, retire_i);
        pend_d     = pend_q;
        overflow_o = 1'b0;
        if (mask_i) begin
            pend_d = '0;
        end else begin
            unique case (op)
                PEND_INC: begin
                    if (full) overflow_o = 1'b1;
                    else      pend_d     = pend_q + 1'b1;
                end
                PEND_DEC: pend_d = pend_q - 1'b1;
                default:  pend_d = pend_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

endmodule

// File: rtl/trig_event_complete.sv
// Merges per-link event completions into a single last-flag pulse per event.
// Optional completion timeout enabled by TRIG_EVENT_COMPLETE_TIMEOUT_EN.
module trig_event_complete
    import trig_pkg::*;
#(
    parameter int unsigned NLINKS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1250000,
    parameter string       DEBUG          = "TRUE"
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic [NLINKS-1:0] link_done_i,
    input  logic [NLINKS-1:0] link_mask_i,
    output logic              last_flag_o,
    output logic              panic_o,
    output logic [NLINKS-1:0] link_err_o
);

    logic [NLINKS-1:0] nonzero;
    logic [NLINKS-1:0] overflow;
    pend_t             pend [NLINKS];
    logic              any_unmasked;
    logic              any_pending;
    logic              ready;
    logic              timeout_hit;

    logic              last_flag_q;
    logic              panic_q;
    logic [NLINKS-1:0] link_err_q;

    assign any_unmasked = !(&link_mask_i);
    assign ready        = any_unmasked && (&(nonzero | link_mask_i));
    assign any_pending  = |nonzero;

    for (genvar i = 0; i < NLINKS; i++) begin : g_link
        trig_link_pending u_pend (
            .sys_clk_i  (sys_clk_i),
            .rst_i      (rst_i),
            .done_i     (link_done_i[i]),
            .retire_i   (ready),
            .mask_i     (link_mask_i[i]),
            .nonzero_o  (nonzero[i]),
            .overflow_o (overflow[i]),
            .pend_o     (pend[i])
        );
    end

`ifdef TRIG_EVENT_COMPLETE_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] to_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (ready || !any_pending)   to_cnt_d = '0;
        else if (to_cnt_q != TO_LIMIT) to_cnt_d = to_cnt_q + 1'b1;
    end

    // Fire on the edge the counter lands on the limit; it then saturates.
    assign timeout_hit = !ready && any_pending && (to_cnt_d == TO_LIMIT);

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            last_flag_q <= 1'b0;
            panic_q     <= 1'b0;
            link_err_q  <= '0;
        end else begin
            last_flag_q <= ready;
            link_err_q  <= link_err_q | overflow;
            panic_q     <= panic_q | (|overflow) | timeout_hit;
        end
    end

    assign last_flag_o = last_flag_q;
    assign panic_o     = panic_q;
    assign link_err_o  = link_err_q;

    if (DEBUG == "TRUE") begin : g_debug
        (* mark_debug = "true" *) logic [NLINKS*PEND_WIDTH+1:0] ila_probe_unused;
        always_comb begin
            ila_probe_unused = '0;
            for (int unsigned i = 0; i < NLINKS; i++) begin
                ila_probe_unused[i*PEND_WIDTH +: PEND_WIDTH] = pend[i];
            end
            ila_probe_unused[NLINKS*PEND_WIDTH]     = last_flag_q;
            ila_probe_unused[NLINKS*PEND_WIDTH + 1] = panic_q;
        end
    end

endmodule
